// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline stages and the central pipeline controller.
// Transfer rules: there is no ready signal anywhere. branch_flag is a
// single-cycle valid that qualifies branch_target in that cycle only.
// new_pc_valid is a single-cycle valid that qualifies new_pc, and the PC
// register must load it in that same cycle. The stall request inputs and
// the stall vector are level signals that are re-evaluated every cycle.
interface pipe_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  // Requests coming from the pipeline stages
  logic              stallreq_if;
  logic              stallreq_id;
  logic              stallreq_ex;
  logic              stallreq_mem;
  logic              branch_flag;
  logic [ADDR_W-1:0] branch_target;
  logic              cnt_clr;

  // Controls going back to the pipeline
  logic [5:0]        stall;
  logic              flush;
  logic              new_pc_valid;
  logic [ADDR_W-1:0] new_pc;
  logic              redir_pending;
  logic              err_sticky;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // Pipeline side: raises requests, consumes the controls
  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output branch_flag, branch_target, cnt_clr,
    input  stall, flush, new_pc_valid, new_pc, redir_pending,
    input  err_sticky, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  branch_flag, branch_target, cnt_clr,
    output stall, flush, new_pc_valid, new_pc, redir_pending,
    output err_sticky, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central controller of the 5-stage pipeline: merges stall requests into the
// register-enable vector, sequences EX-resolved redirects (flush + PC reload),
// parks a redirect while EX/MEM is frozen, and counts stall/flush cycles.
module pipe_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic [5:0]        stall_raw;
  logic [5:0]        stall_fin;
  logic              frozen;
  logic              apply;
  logic [ADDR_W-1:0] apply_pc;

  // Raw stall vector: the oldest requesting stage holds itself and everything younger
  always_comb begin
    stall_raw = 6'b000000;
    if (bus.stallreq_mem)      stall_raw = 6'b011111;
    else if (bus.stallreq_ex)  stall_raw = 6'b001111;
    else if (bus.stallreq_id)  stall_raw = 6'b000111;
    else if (bus.stallreq_if)  stall_raw = 6'b000011;
  end

  // A stall at EX or MEM means the EX/MEM boundary cannot advance this cycle
  assign frozen = bus.stallreq_mem | bus.stallreq_ex;

  // Redirect FSM: decides whether a redirect is applied now or parked
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    err_d    = err_q;
    apply    = 1'b0;
    apply_pc = bus.branch_target;
    unique case (state_q)
      RUN: begin
        if (bus.branch_flag) begin
          if (!frozen) begin
            apply    = 1'b1;
            apply_pc = bus.branch_target;
          end else begin
            tgt_d   = bus.branch_target;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        // A second branch while one is parked is a protocol error; the
        // parked target is kept and the new one is dropped.
        if (bus.branch_flag) err_d = 1'b1;
        if (!frozen) begin
          apply    = 1'b1;
          apply_pc = tgt_q;
          state_d  = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Final stall vector: a redirect flushes IF/ID, so their holds are dropped
  always_comb begin
    stall_fin = stall_raw;
    if (apply) stall_fin[2:0] = 3'b000;
  end

  // Saturating counter next values; clear wins over increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if ((stall_fin != 6'b000000) && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (apply && (flush_cnt_q != '1))
        flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  // State, parked target, error flag and counters; reset discards any parked redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      tgt_q       <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Controls are forced quiet while reset is asserted
  assign bus.stall         = rst ? 6'b000000 : stall_fin;
  assign bus.flush         = apply & ~rst;
  assign bus.new_pc_valid  = apply & ~rst;
  assign bus.new_pc        = (apply && !rst) ? apply_pc : '0;
  assign bus.redir_pending = (state_q == PEND) & ~rst;
  assign bus.err_sticky    = err_q;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vectors, a reference model checked on every
// negative clock edge, and literal spot checks of hand-computed values.
module tb_pipe_ctrl;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  pipe_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Parked redirect kept as a queue of at most one target.
  logic [ADDR_W-1:0] exp_q[$];
  bit                m_err = 0;
  int                m_stall_cnt = 0;
  int                m_flush_cnt = 0;

  always @(negedge clk) begin
    int          n;
    logic [5:0]  raw, e_stall;
    bit          fz, redir, e_pend, e_err;
    logic [ADDR_W-1:0] e_pc;

    // Oldest stalling stage N holds N+1 low register enables
    if (bus.stallreq_mem)      n = 5;
    else if (bus.stallreq_ex)  n = 4;
    else if (bus.stallreq_id)  n = 3;
    else if (bus.stallreq_if)  n = 2;
    else                       n = 0;
    raw = 6'((1 << n) - 1);
    fz  = bus.stallreq_mem | bus.stallreq_ex;

    e_pend = (exp_q.size() > 0);
    e_err  = m_err;
    redir  = 0;
    e_pc   = '0;

    chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall_cnt));
    chk("flush_cnt", 64'(bus.flush_cnt), 64'(m_flush_cnt));
    chk("err_sticky", 64'(bus.err_sticky), 64'(e_err));

    if (rst) begin
      chk("stall_rst", 64'(bus.stall), 64'd0);
      chk("flush_rst", 64'(bus.flush), 64'd0);
      chk("npv_rst", 64'(bus.new_pc_valid), 64'd0);
      chk("new_pc_rst", 64'(bus.new_pc), 64'd0);
      chk("pend_rst", 64'(bus.redir_pending), 64'd0);
      exp_q.delete();
      m_err = 0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (e_pend) begin
        if (bus.branch_flag) m_err = 1;
        if (!fz) begin
          redir = 1;
          e_pc  = exp_q.pop_front();
        end
      end else if (bus.branch_flag) begin
        if (fz) exp_q.push_back(bus.branch_target);
        else begin
          redir = 1;
          e_pc  = bus.branch_target;
        end
      end
      e_stall = redir ? (raw & 6'b111000) : raw;
      chk("stall", 64'(bus.stall), 64'(e_stall));
      chk("flush", 64'(bus.flush), 64'(redir));
      chk("new_pc_valid", 64'(bus.new_pc_valid), 64'(redir));
      if (redir) chk("new_pc", 64'(bus.new_pc), 64'(e_pc));
      chk("redir_pending", 64'(bus.redir_pending), 64'(e_pend));
      if (bus.cnt_clr) begin
        m_stall_cnt = 0;
        m_flush_cnt = 0;
      end else begin
        if (e_stall != 0 && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (redir && m_flush_cnt < CNT_MAX) m_flush_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit s_if, input bit s_id, input bit s_ex, input bit s_mem,
                        input bit br, input logic [ADDR_W-1:0] tgt);
    bus.stallreq_if   = s_if;
    bus.stallreq_id   = s_id;
    bus.stallreq_ex   = s_ex;
    bus.stallreq_mem  = s_mem;
    bus.branch_flag   = br;
    bus.branch_target = tgt;
  endtask

  // Advance to just after the negative edge: outputs for current inputs are settled
  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  // Advance to just after the next rising edge: safe point to change inputs
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.cnt_clr = 1'b0;
    set_in(0, 0, 0, 0, 0, '0);
    mid();
    chk("lit_rst_stall", 64'(bus.stall), 64'd0);
    chk("lit_rst_flush", 64'(bus.flush), 64'd0);
    step();
    step();
    rst = 1'b0;
    mid();
    chk("lit_idle_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    step();

    // 1: stall priority
    set_in(0, 1, 0, 1, 0, '0);
    mid(); chk("lit_id_mem", 64'(bus.stall), 64'b011111); step();
    set_in(0, 1, 0, 0, 0, '0);
    mid(); chk("lit_id_only", 64'(bus.stall), 64'b000111); step();
    set_in(0, 0, 0, 0, 0, '0);
    mid(); chk("lit_none", 64'(bus.stall), 64'd0);
    chk("lit_stall_cnt2", 64'(bus.stall_cnt), 64'd2); step();
    set_in(1, 0, 0, 0, 0, '0);
    mid(); chk("lit_if_only", 64'(bus.stall), 64'b000011); step();
    set_in(1, 1, 1, 0, 0, '0);
    mid(); chk("lit_ex_wins", 64'(bus.stall), 64'b001111); step();
    set_in(0, 0, 0, 0, 0, '0);
    mid(); chk("lit_stall_cnt4", 64'(bus.stall_cnt), 64'd4); step();

    // 2: unfrozen branch
    set_in(0, 0, 0, 0, 1, 32'h0000_0100);
    mid();
    chk("lit_br_flush", 64'(bus.flush), 64'd1);
    chk("lit_br_npv", 64'(bus.new_pc_valid), 64'd1);
    chk("lit_br_pc", 64'(bus.new_pc), 64'h100);
    step();
    set_in(0, 0, 0, 0, 0, '0);
    mid();
    chk("lit_br_flush_off", 64'(bus.flush), 64'd0);
    chk("lit_flush_cnt1", 64'(bus.flush_cnt), 64'd1);
    step();

    // 3: frozen branch, redirect when mem drops
    set_in(0, 0, 0, 1, 1, 32'h0000_0200);
    mid(); chk("lit_fz_flush0", 64'(bus.flush), 64'd0); step();
    set_in(0, 0, 0, 1, 0, '0);
    mid(); chk("lit_fz_pend", 64'(bus.redir_pending), 64'd1); step();
    mid(); chk("lit_fz_flush1", 64'(bus.flush), 64'd0); step();
    set_in(0, 0, 0, 0, 0, '0);
    mid();
    chk("lit_fz_redir", 64'(bus.flush), 64'd1);
    chk("lit_fz_pc", 64'(bus.new_pc), 64'h200);
    step();
    mid();
    chk("lit_fz_pend_off", 64'(bus.redir_pending), 64'd0);
    chk("lit_stall_cnt7", 64'(bus.stall_cnt), 64'd7);
    chk("lit_flush_cnt2", 64'(bus.flush_cnt), 64'd2);
    step();

    // 4: flush beats ID stall
    set_in(0, 1, 0, 0, 1, 32'h0000_0300);
    mid();
    chk("lit_fb_stall", 64'(bus.stall), 64'd0);
    chk("lit_fb_pc", 64'(bus.new_pc), 64'h300);
    step();
    set_in(0, 0, 0, 0, 0, '0);
    mid(); chk("lit_flush_cnt3", 64'(bus.flush_cnt), 64'd3); step();

    // 5: second branch while parked, then reset mid-PEND
    set_in(0, 0, 1, 0, 1, 32'h0000_0400); step();
    set_in(0, 0, 1, 0, 1, 32'h0000_0500); step();
    set_in(0, 0, 1, 0, 0, '0);
    mid(); chk("lit_err", 64'(bus.err_sticky), 64'd1); step();
    set_in(0, 0, 0, 0, 0, '0);
    mid(); chk("lit_err_pc", 64'(bus.new_pc), 64'h400); step();
    set_in(0, 0, 1, 0, 1, 32'h0000_0600); step();
    set_in(0, 0, 1, 0, 0, '0);
    mid(); chk("lit_pend2", 64'(bus.redir_pending), 64'd1); step();
    rst = 1'b1;
    mid(); chk("lit_pend_in_rst", 64'(bus.redir_pending), 64'd0); step();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, '0);
    mid();
    chk("lit_post_rst_flush", 64'(bus.flush), 64'd0);
    chk("lit_post_rst_err", 64'(bus.err_sticky), 64'd0);
    step();

    // 6: counter saturation and clear
    set_in(0, 0, 0, 1, 0, '0);
    for (int i = 0; i < CNT_MAX + 3; i++) step();
    mid(); chk("lit_sat", 64'(bus.stall_cnt), 64'(CNT_MAX)); step();
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    set_in(0, 0, 0, 0, 0, '0);
    mid();
    chk("lit_clr_stall", 64'(bus.stall_cnt), 64'd0);
    chk("lit_clr_flush", 64'(bus.flush_cnt), 64'd0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage RISC-V core (IF, ID, EX, MEM, WB).
- Merges per-stage stall requests into one stall vector that drives the enable of every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb).
- Sequences branch/jump redirects resolved in EX: flush of the two younger stages plus PC reload.
- Holds a redirect that arrives while the pipe is frozen until the pipe can move.
- Keeps saturating stall/flush performance counters.

Parameters:
ADDR_W, 32, PC / branch target width
CNT_W, 32, width of both performance counters

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset; synchronous, active-high
stallreq_if  in  1  IF stage cannot deliver instruction this cycle
stallreq_id  in  1  ID hazard, e.g. load-use
stallreq_ex  in  1  EX multi-cycle op busy
stallreq_mem  in  1  data memory access not complete
branch_flag  in  1  one-cycle pulse: EX resolved a taken branch/jump
branch_target  in  ADDR_W  redirect target, valid with branch_flag
cnt_clr  in  1  synchronous clear of both counters
stall  out  6  bit0 pc, 1 if_id, 2 id_ex, 3 ex_mem, 4 mem_wb, 5 reserved (always 0); 1 = hold
flush  out  1  clear if_id and id_ex to NOP this cycle
new_pc_valid  out  1  PC loads new_pc this cycle
new_pc  out  ADDR_W  redirect address
redir_pending  out  1  state == PEND
err_sticky  out  1  branch_flag received while PEND; cleared only by rst
stall_cnt  out  CNT_W  cycles with any stall bit set
flush_cnt  out  CNT_W  number of flushes issued

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=RUN; held target=0; err_sticky=0; both counters=0.
  - stall, flush, new_pc_valid, new_pc and redir_pending are 0 during any cycle rst is high.
- Raw stall vector, combinational, highest requester wins:
  - mem -> 011111
  - ex -> 001111
  - id -> 000111
  - if -> 000011
  - none -> 000000
- frozen = stallreq_mem | stallreq_ex (the EX/MEM boundary cannot advance).
- State machine, 2 states:
  - RUN:
    - branch_flag & !frozen: apply redirect this cycle with new_pc=branch_target. Stay in RUN.
    - branch_flag & frozen: latch branch_target, go to PEND. No flush this cycle.
  - PEND:
    - While frozen: hold. Outputs flush=0, new_pc_valid=0.
    - First cycle !frozen: apply redirect using the latched target, return to RUN.
    - branch_flag in PEND: ignored (the target is not overwritten) and err_sticky<=1.
- Applying a redirect (combinational, same cycle):
  - flush=1, new_pc_valid=1.
  - stall[2:0] forced to 0: the flush dominates IF/ID stall requests.
  - stall[4:3] come from the raw vector (both 0, since !frozen).
- Latency:
  - Unfrozen branch: 0 cycles (same cycle as the pulse).
  - Frozen branch: redirect in the first unfrozen cycle after the freeze ends.
- Counters:
  - Counter updates use the final stall vector.
  - Both counters saturate at all-ones.
  - cnt_clr has priority over increment; rst has priority over both.
  - stall_cnt += 1 in each cycle with a nonzero final stall.
  - flush_cnt += 1 in each cycle with flush=1.
- Mid-PEND reset: the pending redirect is discarded and state returns to RUN.
- redir_pending is registered: it equals (state==PEND).

Test Plan:
1. Stall priority: rst released; assert stallreq_id=1 and stallreq_mem=1 together -> stall=011111. Drop mem only -> stall=000111. Drop id -> stall=000000. Each stalled cycle increments stall_cnt.
2. Unfrozen branch: branch_flag=1, target=0x0000_0100, no stalls -> in the same cycle flush=1, new_pc_valid=1, new_pc=0x100; next cycle flush=0 and flush_cnt=1.
3. Frozen branch: stallreq_mem=1 for 3 cycles, branch_flag pulse (target 0x200) in the first of them -> redir_pending=1 from the next cycle and flush=0 while frozen. Mem drops -> that cycle flush=1, new_pc=0x200; next cycle redir_pending=0.
4. Flush beats ID stall: stallreq_id=1 together with an unfrozen branch (target 0x300) -> stall=000000, flush=1, new_pc=0x300.
5. Protocol error: enter PEND with target 0x400, pulse branch_flag with 0x500 while still frozen -> err_sticky=1, then redirect uses 0x400. Assert rst during a later PEND -> state RUN, no flush after reset, err_sticky=0.
6. Counters: force stall_cnt to all-ones, then continue stalling -> stall_cnt holds all-ones. cnt_clr together with a stall -> next cycle both counters are 0.
